// File: rtl/seg7_capture.sv
// Loopback reader for a multiplexed active-low seven-segment bus. It recovers
// the hex nibble for each digit, flags undecodable patterns and signals frame completion.
module seg7_capture #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4,
  parameter int CW     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_ok,
  output logic                  frame_valid,
  output logic                  err
);

  localparam int PW = DIGITS + 7;

  logic [PW-1:0]       r_sync1;
  logic [PW-1:0]       r_s;
  logic [PW-1:0]       r_p;
  logic [CW-1:0]       r_cnt;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_ok;
  logic                r_frame;
  logic                r_err;

  logic [DIGITS-1:0]   w_sel;
  logic [6:0]          w_seg_on;
  logic [4:0]          w_dec;
  logic                w_onehot;
  logic                w_commit;
  logic [DIGITS-1:0]   w_seen_next;

  // Returns {valid, nibble} for a lit-segment pattern ordered g..a.
  function automatic logic [4:0] seg_decode(input logic [6:0] on);
    logic [4:0] res;
    case (on)
      7'b0111111: res = {1'b1, 4'h0};
      7'b0000110: res = {1'b1, 4'h1};
      7'b1011011: res = {1'b1, 4'h2};
      7'b1001111: res = {1'b1, 4'h3};
      7'b1100110: res = {1'b1, 4'h4};
      7'b1101101: res = {1'b1, 4'h5};
      7'b1111101: res = {1'b1, 4'h6};
      7'b0000111: res = {1'b1, 4'h7};
      7'b1111111: res = {1'b1, 4'h8};
      7'b1101111: res = {1'b1, 4'h9};
      7'b1110111: res = {1'b1, 4'hA};
      7'b1111100: res = {1'b1, 4'hB};
      7'b0111001: res = {1'b1, 4'hC};
      7'b1011110: res = {1'b1, 4'hD};
      7'b1111001: res = {1'b1, 4'hE};
      7'b1110001: res = {1'b1, 4'hF};
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  assign w_sel       = ~r_s[PW-1:7];
  assign w_seg_on    = ~r_s[6:0];
  assign w_dec       = seg_decode(w_seg_on);
  assign w_onehot    = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
  // Fires on exactly one edge per stable run; the saturated counter blocks repeats.
  assign w_commit    = (r_s == r_p) && (r_cnt == CW'(STABLE - 1));
  assign w_seen_next = r_seen | w_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_s     <= '1;
      r_p     <= '1;
      r_cnt   <= CW'(STABLE);
      r_seen  <= '0;
      r_value <= '0;
      r_ok    <= '0;
      r_frame <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= {dig_n, seg_n};
      r_s     <= r_sync1;
      r_p     <= r_s;
      if (r_s != r_p)
        r_cnt <= '0;
      else if (r_cnt != CW'(STABLE))
        r_cnt <= r_cnt + CW'(1);

      r_err   <= 1'b0;
      r_frame <= 1'b0;
      // Blanked or overlapping digit selects are ignored entirely.
      if (w_commit && w_onehot) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (w_sel[i]) begin
            if (w_dec[4])
              r_value[4*i +: 4] <= w_dec[3:0];
            r_ok[i] <= w_dec[4];
          end
        end
        r_err <= ~w_dec[4];
        if (&w_seen_next) begin
          r_frame <= 1'b1;
          r_seen  <= '0;
        end else begin
          r_seen  <= w_seen_next;
        end
      end
    end
  end

  assign value       = r_value;
  assign digit_ok    = r_ok;
  assign frame_valid = r_frame;
  assign err         = r_err;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus random scans,
// compared every cycle against a pin-history reference model.
module tb_seg7_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam int CW     = 3;
  localparam int H      = STABLE + 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  dig_n = 4'hF;
  logic [15:0] value;
  logic [3:0]  digit_ok;
  logic        frame_valid;
  logic        err;

  seg7_capture #(.DIGITS(DIGITS), .STABLE(STABLE), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_n(dig_n),
    .value(value), .digit_ok(digit_ok), .frame_valid(frame_valid), .err(err));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int frames_obs = 0;
  int errs_obs   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pin samples per edge; a commit happens on the edge that
  // sees a value that has been sampled STABLE+1 times in a row, after a change.
  logic [10:0] hist[$];
  logic [15:0] m_value;
  logic [3:0]  m_ok;
  logic [3:0]  m_seen;
  logic        m_err;
  logic        m_frame;

  task automatic model_reset();
    hist.delete();
    repeat (H) hist.push_back(11'h7FF);
    m_value = '0; m_ok = '0; m_seen = '0; m_err = 1'b0; m_frame = 1'b0;
  endtask

  task automatic model_edge(input logic [10:0] pins);
    bit run;
    logic [3:0] sel;
    logic [6:0] on;
    int k, nib;
    hist.push_back(pins);
    void'(hist.pop_front());
    m_err = 1'b0; m_frame = 1'b0;
    run = (hist[1] != hist[0]);
    for (int i = 2; i <= STABLE + 1; i++)
      if (hist[i] != hist[1]) run = 0;
    if (!run) return;
    sel = ~hist[1][10:7];
    if ($countones(sel) != 1) return;
    k = 0;
    for (int i = 0; i < DIGITS; i++) if (sel[i]) k = i;
    on = ~hist[1][6:0];
    nib = -1;
    for (int n = 0; n < 16; n++) if (SEG_TAB[n] == on) nib = n;
    if (nib >= 0) begin
      m_value[4*k +: 4] = 4'(nib);
      m_ok[k] = 1'b1;
    end else begin
      m_ok[k] = 1'b0;
      m_err = 1'b1;
    end
    m_seen[k] = 1'b1;
    if (m_seen == 4'hF) begin
      m_frame = 1'b1;
      m_seen = '0;
    end
  endtask

  task automatic tick(input logic [3:0] d, input logic [6:0] s);
    dig_n = d; seg_n = s;
    @(posedge clk);
    model_edge({d, s});
    @(negedge clk);
    chk("value", 32'(value), 32'(m_value));
    chk("digit_ok", 32'(digit_ok), 32'(m_ok));
    chk("err", 32'(err), 32'(m_err));
    chk("frame_valid", 32'(frame_valid), 32'(m_frame));
    if (frame_valid) frames_obs++;
    if (err) errs_obs++;
  endtask

  task automatic show(input int k, input int nib, input int cycles);
    repeat (cycles) tick(~(4'b1 << k), ~SEG_TAB[nib]);
  endtask

  task automatic show_raw(input int k, input logic [6:0] on, input int cycles);
    repeat (cycles) tick(~(4'b1 << k), ~on);
  endtask

  task automatic blank(input int cycles);
    repeat (cycles) tick(4'hF, 7'h7F);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_ok", 32'(digit_ok), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_frame", 32'(frame_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int f0, e0;
    model_reset();
    #1;
    chk("por_value", 32'(value), 32'h0);
    chk("por_ok", 32'(digit_ok), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle pins
    blank(20);
    chk("idle_frames", 32'(frames_obs), 32'h0);
    chk("idle_errs", 32'(errs_obs), 32'h0);

    // 2: digit 0 shows 1, then keeps holding
    show(0, 1, 10);
    chk("t2_value", 32'(value[3:0]), 32'h1);
    chk("t2_ok", 32'(digit_ok), 32'h1);
    e0 = errs_obs;
    show(0, 1, 50);
    chk("t2_hold_err", 32'(errs_obs - e0), 32'h0);

    // 3: full scan 4,A,7,F
    f0 = frames_obs;
    blank(3);
    show(0, 4, 12); blank(3);
    show(1, 10, 12); blank(3);
    show(2, 7, 12); blank(3);
    show(3, 15, 12); blank(3);
    chk("t3_value", 32'(value), 32'hF7A4);
    chk("t3_ok", 32'(digit_ok), 32'hF);
    chk("t3_frames", 32'(frames_obs - f0), 32'h1);

    // 4: all segments off on digit 2
    e0 = errs_obs;
    show_raw(2, 7'h00, 10); blank(3);
    chk("t4_errs", 32'(errs_obs - e0), 32'h1);
    chk("t4_ok", 32'(digit_ok), 32'hB);
    chk("t4_value", 32'(value), 32'hF7A4);

    // 5: short glitch to 8 on digit 1
    show(1, 5, 10);
    show(1, 8, 3);
    show(1, 5, 10);
    chk("t5_value", 32'(value), 32'hF754);

    // 6: reset mid-frame, then a full frame, then overlapping selects
    show(0, 9, 10); show(1, 3, 10);
    reset_pulse();
    f0 = frames_obs;
    show(0, 4, 10); show(1, 3, 10); show(2, 2, 10);
    chk("t6_partial_frames", 32'(frames_obs - f0), 32'h0);
    show(3, 1, 10);
    chk("t6_frames", 32'(frames_obs - f0), 32'h1);
    chk("t6_value", 32'(value), 32'h1234);
    repeat (10) tick(4'b1100, ~SEG_TAB[8]);
    blank(4);
    chk("t6_overlap_value", 32'(value), 32'h1234);

    // Random scans: mostly clean digits, some garbage, blanks and overlaps
    for (int r = 0; r < 300; r++) begin
      int len, kind;
      len = $urandom_range(1, 12);
      kind = $urandom_range(0, 9);
      if (kind < 6)      show($urandom_range(0, 3), $urandom_range(0, 15), len);
      else if (kind < 8) show_raw($urandom_range(0, 3), 7'($urandom), len);
      else if (kind < 9) blank(len);
      else               repeat (len) tick(4'($urandom), 7'($urandom));
      if (r == 150) reset_pulse();
    end
    blank(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
